// File: rtl/compiler_token_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : compiler_token_sequencer
// Description : Forth compiler front end. Splits a UART character stream into
//               whitespace-delimited words, turns decimal literals into PUSH
//               tokens locally, sends every other word through the external
//               lookup unit, and hands opcode/data tokens to the execution
//               unit over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module compiler_token_sequencer #(
    parameter int WIDTH    = 32,
    parameter int DATA     = 32,
    parameter int OPCODE   = 16,
    localparam int LEN_BITS = $clog2(WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_rx_ready,
    output logic [8*WIDTH-1:0]    o_word,
    output logic [LEN_BITS-1:0]   o_len,
    output logic                  o_lookup_en,
    input  logic [OPCODE-1:0]     i_lu_opcode,
    input  logic [DATA-1:0]       i_lu_data,
    input  logic                  i_lu_err,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OPCODE-1:0]     o_opcode,
    output logic [DATA-1:0]       o_data,
    output logic                  o_err
);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WAIT   = 2'd2,
        ST_EMIT   = 2'd3
    } state_t;

    // Longest legal word leaves one slot unused, so the length never wraps.
    localparam logic [LEN_BITS-1:0] c_MAX_LEN = LEN_BITS'(WIDTH - 1);
    localparam logic [OPCODE-1:0]   c_OP_PUSH = OPCODE'(1);
    localparam logic [DATA-1:0]     c_TEN     = DATA'(10);

    state_t                r_state;
    logic [8*WIDTH-1:0]    r_word;
    logic [LEN_BITS-1:0]   r_len;
    logic [DATA-1:0]       r_acc;
    logic                  r_is_num;
    logic                  r_ovf;
    logic                  r_lookup_en;
    logic                  r_valid;
    logic [OPCODE-1:0]     r_opcode;
    logic [DATA-1:0]       r_data;
    logic                  r_err;

    logic                  w_delim;
    logic                  w_is_digit;
    logic [DATA-1:0]       w_acc_next;
    logic [LEN_BITS+2:0]   w_slot;

    // Character classification for the byte currently offered by the UART.
    always_comb begin
        w_delim    = (i_rx_data == 8'h20) || (i_rx_data == 8'h09) ||
                     (i_rx_data == 8'h0A) || (i_rx_data == 8'h0D);
        w_is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
        // ASCII digits carry their value in the low nibble; the product wraps.
        w_acc_next = (r_acc * c_TEN) + {{(DATA-4){1'b0}}, i_rx_data[3:0]};
        w_slot     = {r_len, 3'b000};
    end

    // Sequencer: word accumulation, literal conversion, lookup and handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_ACCUM;
            r_word      <= '0;
            r_len       <= '0;
            r_acc       <= '0;
            r_is_num    <= 1'b1;
            r_ovf       <= 1'b0;
            r_lookup_en <= 1'b0;
            r_valid     <= 1'b0;
            r_opcode    <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_lookup_en <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    if (i_rx_valid) begin
                        if (!w_delim) begin
                            if (r_len < c_MAX_LEN) begin
                                r_word[w_slot +: 8] <= i_rx_data;
                                r_len               <= r_len + LEN_BITS'(1);
                            end else begin
                                r_ovf <= 1'b1;
                            end
                            if (w_is_digit) begin
                                r_acc <= w_acc_next;
                            end else begin
                                r_is_num <= 1'b0;
                            end
                        end else if (r_len != '0) begin
                            if (r_ovf) begin
                                // Oversized word: report and discard it.
                                r_err    <= 1'b1;
                                r_word   <= '0;
                                r_len    <= '0;
                                r_acc    <= '0;
                                r_is_num <= 1'b1;
                                r_ovf    <= 1'b0;
                            end else if (r_is_num) begin
                                r_opcode <= c_OP_PUSH;
                                r_data   <= r_acc;
                                r_valid  <= 1'b1;
                                r_state  <= ST_EMIT;
                            end else begin
                                r_lookup_en <= 1'b1;
                                r_state     <= ST_LOOKUP;
                            end
                        end
                    end
                end
                ST_LOOKUP: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Lookup unit answers one cycle after its enable.
                    if (i_lu_err) begin
                        r_err    <= 1'b1;
                        r_word   <= '0;
                        r_len    <= '0;
                        r_acc    <= '0;
                        r_is_num <= 1'b1;
                        r_ovf    <= 1'b0;
                        r_state  <= ST_ACCUM;
                    end else begin
                        r_opcode <= i_lu_opcode;
                        r_data   <= i_lu_data;
                        r_valid  <= 1'b1;
                        r_state  <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (i_ready) begin
                        r_valid  <= 1'b0;
                        r_word   <= '0;
                        r_len    <= '0;
                        r_acc    <= '0;
                        r_is_num <= 1'b1;
                        r_ovf    <= 1'b0;
                        r_state  <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign o_rx_ready  = (r_state == ST_ACCUM);
    assign o_word      = r_word;
    assign o_len       = r_len;
    assign o_lookup_en = r_lookup_en;
    assign o_valid     = r_valid;
    assign o_opcode    = r_opcode;
    assign o_data      = r_data;
    assign o_err       = r_err;

endmodule
`default_nettype wire
